// File: rtl/addsub_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_pkg: shared types and sizing helpers for the skip adder.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEFAULT_BLK = 32;

    function automatic int num_stages(input int w, input int blk);
        return w / blk;
    endfunction

    // Bit offset of stage k's operand-skew slice (stage k holds blocks k+1..ns-1)
    function automatic int skew_off(input int ns, input int blk, input int k);
        return (k <= 0) ? 0 : blk * (k * (ns - 1) - (k * (k - 1)) / 2);
    endfunction

    // Bit offset of stage k's result-deskew slice (stage k holds blocks 0..k)
    function automatic int desk_off(input int blk, input int k);
        return (k <= 0) ? 0 : blk * ((k * (k + 1)) / 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/skip_block.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | skip_block: BLK-bit ripple add with propagate-driven carry skip.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module skip_block
    import addsub_pkg::*;
#(
    parameter int BLK = DEFAULT_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK:0] ripple;
    logic         prop;

    always_comb begin
        ripple = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, cin};
        prop   = &(a ^ b);
        sum    = ripple[BLK-1:0];
        cout   = prop ? cin : ripple[BLK];
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_skip_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipelined_skip_addsub: W-bit add/sub, one BLK-bit block per stage. |
// | Optional flags (out_zero/out_neg/out_ovf) under ADDSUB_FLAGS_EN.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pipelined_skip_addsub
    import addsub_pkg::*;
#(
    parameter int W   = 128,
    parameter int BLK = DEFAULT_BLK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
`ifdef ADDSUB_FLAGS_EN
    ,
    output logic         out_zero,
    output logic         out_neg,
    output logic         out_ovf
`endif
);

    localparam int NS       = num_stages(W, BLK);
    localparam int SKW_BITS = (NS > 1) ? (BLK * NS * (NS - 1)) / 2 : 1;
    localparam int DSK_BITS = (BLK * NS * (NS + 1)) / 2;
    localparam int FIN_OFF  = desk_off(BLK, NS - 1);

    if ((W % BLK) != 0 || W < BLK) begin : g_bad_cfg
        $error("pipelined_skip_addsub: W must be a non-zero multiple of BLK");
    end

    logic [NS-1:0]       valid_q, valid_d;
    logic [NS-1:0]       carry_q, carry_d;
    logic [SKW_BITS-1:0] a_skew_q, a_skew_d;
    logic [SKW_BITS-1:0] b_skew_q, b_skew_d;
    logic [DSK_BITS-1:0] sum_q, sum_d;

    logic [BLK-1:0] blk_a [NS];
    logic [BLK-1:0] blk_b [NS];
    logic [BLK-1:0] blk_s [NS];
    logic [NS-1:0]  blk_ci;
    logic [NS-1:0]  blk_co;

    logic [W-1:0] b_eff;
    logic         advance;
    op_e          op;

    always_comb begin
        op    = op_e'(in_sub);
        b_eff = (op == OP_SUB) ? ~in_b : in_b;
    end

    assign advance   = ~valid_q[NS-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[NS-1];
    assign out_sum   = sum_q[FIN_OFF +: W];
    assign out_cout  = carry_q[NS-1];

    for (genvar k = 0; k < NS; k++) begin : g_stage
        localparam int DOFF = desk_off(BLK, k);
        localparam int DPRV = desk_off(BLK, k - 1);

        if (k == 0) begin : g_first
            assign blk_a[k]   = in_a[BLK-1:0];
            assign blk_b[k]   = b_eff[BLK-1:0];
            assign blk_ci[k]  = in_cin;
            assign valid_d[k] = in_valid;
        end else begin : g_next
            localparam int SPRV = skew_off(NS, BLK, k - 1);
            assign blk_a[k]   = a_skew_q[SPRV +: BLK];
            assign blk_b[k]   = b_skew_q[SPRV +: BLK];
            assign blk_ci[k]  = carry_q[k-1];
            assign valid_d[k] = valid_q[k-1];
            for (genvar j = 0; j < k; j++) begin : g_deskew
                assign sum_d[DOFF + j*BLK +: BLK] = sum_q[DPRV + j*BLK +: BLK];
            end
        end

        skip_block #(
            .BLK (BLK)
        ) u_blk (
            .a    (blk_a[k]),
            .b    (blk_b[k]),
            .cin  (blk_ci[k]),
            .sum  (blk_s[k]),
            .cout (blk_co[k])
        );

        assign carry_d[k]                 = blk_co[k];
        assign sum_d[DOFF + k*BLK +: BLK] = blk_s[k];

        // Upper operand blocks ride along until their stage consumes them
        if (k < NS - 1) begin : g_skew
            localparam int SOFF = skew_off(NS, BLK, k);
            for (genvar j = k + 1; j < NS; j++) begin : g_blk
                if (k == 0) begin : g_src_in
                    assign a_skew_d[SOFF + (j-k-1)*BLK +: BLK] = in_a[j*BLK +: BLK];
                    assign b_skew_d[SOFF + (j-k-1)*BLK +: BLK] = b_eff[j*BLK +: BLK];
                end else begin : g_src_prev
                    localparam int SPRV = skew_off(NS, BLK, k - 1);
                    assign a_skew_d[SOFF + (j-k-1)*BLK +: BLK] = a_skew_q[SPRV + (j-k)*BLK +: BLK];
                    assign b_skew_d[SOFF + (j-k-1)*BLK +: BLK] = b_skew_q[SPRV + (j-k)*BLK +: BLK];
                end
            end
        end
    end

    if (NS == 1) begin : g_no_skew
        assign a_skew_d = '0;
        assign b_skew_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            carry_q  <= '0;
            a_skew_q <= '0;
            b_skew_q <= '0;
            sum_q    <= '0;
        end else if (advance) begin
            valid_q  <= valid_d;
            carry_q  <= carry_d;
            a_skew_q <= a_skew_d;
            b_skew_q <= b_skew_d;
            sum_q    <= sum_d;
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q,  neg_d;
    logic ovf_q,  ovf_d;
    logic msb_carry;

    always_comb begin
        msb_carry = blk_s[NS-1][BLK-1] ^ blk_a[NS-1][BLK-1] ^ blk_b[NS-1][BLK-1];
        zero_d    = (sum_d[FIN_OFF +: W] == '0);
        neg_d     = sum_d[FIN_OFF + W - 1];
        ovf_d     = msb_carry ^ blk_co[NS-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (advance) begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_zero = zero_q;
    assign out_neg  = neg_q;
    assign out_ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_skip_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipelined_skip_addsub: directed bench for 128/32 and 32/32.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pipelined_skip_addsub;

    localparam int W  = 128;
    localparam int BLK = 32;
    localparam int W1 = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, out_cout;
    logic [W-1:0] in_a = '0, in_b = '0, out_sum;

    logic          s_in_valid = 1'b0, s_in_cin = 1'b0, s_in_sub = 1'b0, s_out_ready = 1'b1;
    logic          s_in_ready, s_out_valid, s_out_cout;
    logic [W1-1:0] s_in_a = '0, s_in_b = '0, s_out_sum;

`ifdef ADDSUB_FLAGS_EN
    logic out_zero, out_neg, out_ovf;
    logic s_out_zero, s_out_neg, s_out_ovf;
`endif

    pipelined_skip_addsub #(.W(W), .BLK(BLK)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
`ifdef ADDSUB_FLAGS_EN
        , .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf)
`endif
    );

    pipelined_skip_addsub #(.W(W1), .BLK(W1)) dut_single (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin), .in_sub(s_in_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_cout(s_out_cout)
`ifdef ADDSUB_FLAGS_EN
        , .out_zero(s_out_zero), .out_neg(s_out_neg), .out_ovf(s_out_ovf)
`endif
    );

    task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        bit found = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            lat++;
            @(negedge clk);
            if (out_valid) found = 1'b1;
            else @(posedge clk);
        end
        if (!found) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %h expected 0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %b expected 0", out_cout); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_add();
        int lat;
        out_ready = 1'b1;
        push_one(128'd1, 128'd1, 1'b0, 1'b0);
        wait_out(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
        checks++; if (out_sum !== 128'd2) begin errors++; $display("FAIL add_sum: got %h expected 2", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL add_cout: got %b expected 0", out_cout); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_pulse_width: out_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_skip_path();
        int lat;
        push_one({W{1'b1}}, '0, 1'b1, 1'b0);
        wait_out(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL skip_latency: got %0d expected 4", lat); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL skip_sum: got %h expected 0", out_sum); end
        checks++; if (out_cout !== 1'b1) begin errors++; $display("FAIL skip_cout: got %b expected 1", out_cout); end
`ifdef ADDSUB_FLAGS_EN
        checks++; if ({out_zero, out_neg, out_ovf} !== 3'b100) begin errors++; $display("FAIL skip_flags: got zno=%b%b%b expected 100", out_zero, out_neg, out_ovf); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        int lat;
        logic [W-1:0] exp_s;
        exp_s = {{(W-1){1'b1}}, 1'b0};
        push_one(128'd5, 128'd7, 1'b1, 1'b1);
        wait_out(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency: got %0d expected 4", lat); end
        checks++; if (out_sum !== exp_s) begin errors++; $display("FAIL sub_sum: got %h expected %h", out_sum, exp_s); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL sub_cout: got %b expected 0", out_cout); end
`ifdef ADDSUB_FLAGS_EN
        checks++; if ({out_zero, out_neg, out_ovf} !== 3'b010) begin errors++; $display("FAIL sub_flags: got zno=%b%b%b expected 010", out_zero, out_neg, out_ovf); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        logic [W-1:0] v_a [N];
        logic [W-1:0] v_b [N];
        logic [W-1:0] v_s [N];
        logic         v_cin [N];
        logic         v_sub [N];
        logic         v_co [N];
        v_a[0] = 128'd3;  v_b[0] = 128'd4; v_cin[0] = 0; v_sub[0] = 0; v_s[0] = 128'd7; v_co[0] = 0;
        v_a[1] = 128'd10; v_b[1] = 128'd3; v_cin[1] = 1; v_sub[1] = 1; v_s[1] = 128'd7; v_co[1] = 1;
        v_a[2] = 128'd0;  v_b[2] = 128'd0; v_cin[2] = 1; v_sub[2] = 1; v_s[2] = 128'd0; v_co[2] = 1;
        v_a[3] = {W{1'b1}}; v_b[3] = 128'd1; v_cin[3] = 0; v_sub[3] = 0; v_s[3] = 128'd0; v_co[3] = 1;
        v_a[4] = 128'hFFFF_FFFF; v_b[4] = 128'd1; v_cin[4] = 0; v_sub[4] = 0;
        v_s[4] = 128'h1_0000_0000; v_co[4] = 0;
        v_a[5] = 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; v_b[5] = 128'd0; v_cin[5] = 1; v_sub[5] = 0;
        v_s[5] = 128'h0000_0001_0000_0000_0000_0000_0000_0000; v_co[5] = 0;
        v_a[6] = 128'd0; v_b[6] = 128'd1; v_cin[6] = 0; v_sub[6] = 1;
        v_s[6] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE; v_co[6] = 0;
        v_a[7] = 128'h8000_0000_0000_0000_0000_0000_0000_0000; v_b[7] = 128'd1; v_cin[7] = 1; v_sub[7] = 1;
        v_s[7] = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; v_co[7] = 1;

        out_ready = 1'b1;
        for (int c = 0; c < N + 5; c++) begin
            if (c < N) begin
                in_valid = 1'b1; in_a = v_a[c]; in_b = v_b[c]; in_cin = v_cin[c]; in_sub = v_sub[c];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== (c >= 3 && c < N + 3)) begin
                errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", c, out_valid, (c >= 3 && c < N + 3));
            end
            if (c >= 3 && c < N + 3) begin
                checks++;
                if (out_sum !== v_s[c-3] || out_cout !== v_co[c-3]) begin
                    errors++; $display("FAIL b2b_result[%0d]: got %b/%h expected %b/%h", c - 3, out_cout, out_sum, v_co[c-3], v_s[c-3]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]   pat;
        logic [W-1:0] held;
        logic         stall;
        int           sent, recv;
        pat = 4'b1001;
        sent = 0; recv = 0;
        for (int c = 0; c < 200 && recv < 10; c++) begin
            out_ready = pat[c % 4];
            in_valid  = (sent < 10);
            in_a = W'(sent); in_b = W'(sent); in_cin = 1'b0; in_sub = 1'b0;
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", c, in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_sum !== W'(2 * recv) || out_cout !== 1'b0) begin
                    errors++; $display("FAIL bp_result[%0d]: got %b/%h expected 0/%h", recv, out_cout, out_sum, W'(2 * recv));
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            stall = out_valid && !out_ready;
            held  = out_sum;
            @(posedge clk);
            @(negedge clk);
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_sum !== held) begin
                    errors++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", c, out_valid, out_sum, held);
                end
            end
        end
        checks++; if (recv !== 10) begin errors++; $display("FAIL bp_count: got %0d results expected 10", recv); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra[%0d]: out_valid got %b expected 0", c, out_valid); end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = W'(i + 1); in_b = 128'd1; in_cin = 1'b0; in_sub = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_assert: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d]: out_valid got %b expected 0", c, out_valid); end
        end
    endtask

    task automatic test_single_stage();
        logic [32:0]   exp_q [$];
        logic [32:0]   e;
        logic [W1-1:0] bb;
        int            recv;
        s_out_ready = 1'b1;
        s_in_a = 32'hFFFF_FFFF; s_in_b = 32'd1; s_in_cin = 1'b0; s_in_sub = 1'b0; s_in_valid = 1'b1;
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL ns1_latency: out_valid got %b expected 1", s_out_valid); end
        checks++; if (s_out_sum !== 32'd0 || s_out_cout !== 1'b1) begin errors++; $display("FAIL ns1_result: got %b/%h expected 1/00000000", s_out_cout, s_out_sum); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL ns1_pulse: out_valid got %b expected 0", s_out_valid); end

        recv = 0;
        for (int c = 0; c < 40000 && recv < 10000; c++) begin
            s_out_ready = ($urandom_range(0, 3) != 0);
            s_in_valid  = ($urandom_range(0, 7) != 0);
            s_in_a = $urandom; s_in_b = $urandom;
            s_in_cin = $urandom_range(0, 1); s_in_sub = $urandom_range(0, 1);
            #1;
            if (s_out_valid && s_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL ns1_rand_extra: got %b/%h with nothing outstanding", s_out_cout, s_out_sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({s_out_cout, s_out_sum} !== e) begin
                        errors++; $display("FAIL ns1_rand[%0d]: got %h expected %h", recv, {s_out_cout, s_out_sum}, e);
                    end
                end
                recv++;
            end
            if (s_in_valid && s_in_ready) begin
                bb = s_in_sub ? ~s_in_b : s_in_b;
                e  = {1'b0, s_in_a} + {1'b0, bb} + 33'(s_in_cin);
                exp_q.push_back(e);
            end
            @(posedge clk);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        checks++; if (recv !== 10000) begin errors++; $display("FAIL ns1_rand_count: got %0d expected 10000", recv); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_skip_path();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_single_stage();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
